dac_tx_seq_ctrl: RTL and testbench

- Acc-clock-domain sequencer for the DAC interface block.
- Per transmit request: switches the DAC source from DMA to accelerator path (src_sel), fixes the antenna lane (ant_flag), streams exactly tx_len IQ samples into the 32-deep dual-clock sample FIFO under fulln backpressure, then holds src_sel through a drain window before releasing the DAC to DMA.
- Sits between the TX baseband output and the DAC interface's data_from_acc / data_valid_from_acc / fulln_to_acc / src_sel / ant_flag inputs.

---
 rtl/dac_tx_seq_ctrl_if.sv | 22 ++
 rtl/dac_tx_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dac_tx_seq_ctrl.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_tx_seq_ctrl_if.sv
// Sample stream from the TX baseband plus the write side of the DAC sample FIFO.
// master: the sequencer; slave: the surrounding baseband/FIFO logic.
interface dac_tx_seq_ctrl_if #(
   parameter int unsigned IQ_DATA_WIDTH = 16
);
   logic [2*IQ_DATA_WIDTH-1:0] s_data;
   logic                       s_valid;
   logic                       s_ready;
   logic [2*IQ_DATA_WIDTH-1:0] data_to_dac;
   logic                       data_valid_to_dac;
   logic                       fulln_from_dac;

   modport master (
      input  s_data, s_valid, fulln_from_dac,
      output s_ready, data_to_dac, data_valid_to_dac
   );

   modport slave (
      output s_data, s_valid, fulln_from_dac,
      input  s_ready, data_to_dac, data_valid_to_dac
   );
endinterface

// File: rtl/dac_tx_seq_ctrl.sv
// Acc-domain sequencer that hands the DAC from DMA to the accelerator for one burst of IQ samples.
// Optional underrun watchdog is compiled in with DAC_TX_SEQ_UNDERRUN_EN.
module dac_tx_seq_ctrl #(
   parameter int unsigned IQ_DATA_WIDTH = 16,
   parameter int unsigned LEN_WIDTH     = 16,
   parameter int unsigned CNT_WIDTH     = 8,
   parameter int unsigned MIN_SETUP     = 8
) (
   input  logic                 acc_clk,
   input  logic                 acc_rstn,
   input  logic                 tx_start,
   input  logic                 tx_abort,
   input  logic [LEN_WIDTH-1:0] tx_len,
   input  logic                 tx_ant,
   input  logic [CNT_WIDTH-1:0] cfg_setup_cycles,
   input  logic [CNT_WIDTH-1:0] cfg_drain_cycles,
`ifdef DAC_TX_SEQ_UNDERRUN_EN
   input  logic [CNT_WIDTH-1:0] cfg_underrun_lim,
   output logic                 tx_underrun,
`endif
   dac_tx_seq_ctrl_if.master    tx_if,
   output logic                 src_sel,
   output logic                 ant_flag,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 tx_aborted
);

   typedef enum logic [2:0] {StIdle, StSetup, StStream, StDrain, StDone} state_e;

   localparam logic [CNT_WIDTH-1:0] MinSetup = CNT_WIDTH'(MIN_SETUP);

   state_e                     state_q;
   logic [LEN_WIDTH-1:0]       remain_q;
   logic [CNT_WIDTH-1:0]       cnt_q;
   logic                       aborted_q;
   logic [2*IQ_DATA_WIDTH-1:0] data_q;
   logic                       data_valid_q;

   logic                       start_ok;
   logic                       handshake;
   logic                       last_hs;
   logic                       urun_hit;
   logic                       abort_req;
   logic [CNT_WIDTH-1:0]       setup_load;

   assign start_ok   = (state_q == StIdle) && tx_start && (tx_len != '0);
   assign tx_if.s_ready = (state_q == StStream) && tx_if.fulln_from_dac;
   assign handshake  = tx_if.s_ready && tx_if.s_valid;
   assign last_hs    = handshake && (remain_q == LEN_WIDTH'(1));
   assign abort_req  = tx_abort || urun_hit;
   // Setup guard never shorter than the src_sel/ant_flag synchroniser depth in the DAC domain.
   assign setup_load = (cfg_setup_cycles > MinSetup) ? cfg_setup_cycles : MinSetup;

   assign tx_if.data_to_dac       = data_q;
   assign tx_if.data_valid_to_dac = data_valid_q;

`ifdef DAC_TX_SEQ_UNDERRUN_EN
   logic [CNT_WIDTH-1:0] urun_cnt_q;
   logic                 urun_idle;
   logic                 underrun_q;

   // Starved cycle: the FIFO has room but upstream has nothing to give.
   assign urun_idle = (state_q == StStream) && !tx_if.s_valid && tx_if.fulln_from_dac;
   assign urun_hit  = urun_idle && (cfg_underrun_lim != '0) &&
                      ((urun_cnt_q + CNT_WIDTH'(1)) == cfg_underrun_lim);

   always_ff @(posedge acc_clk or negedge acc_rstn) begin
      if (!acc_rstn) begin
         urun_cnt_q <= '0;
         underrun_q <= 1'b0;
      end else begin
         urun_cnt_q <= (urun_idle && !urun_hit) ? urun_cnt_q + CNT_WIDTH'(1) : '0;
         if (start_ok) begin
            underrun_q <= 1'b0;
         end else if (urun_hit) begin
            underrun_q <= 1'b1;
         end
      end
   end

   assign tx_underrun = underrun_q;
`else
   assign urun_hit = 1'b0;
`endif

   always_ff @(posedge acc_clk or negedge acc_rstn) begin
      if (!acc_rstn) begin
         state_q      <= StIdle;
         remain_q     <= '0;
         cnt_q        <= '0;
         aborted_q    <= 1'b0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         src_sel      <= 1'b0;
         ant_flag     <= 1'b0;
         tx_busy      <= 1'b0;
         tx_done      <= 1'b0;
         tx_aborted   <= 1'b0;
      end else begin
         tx_done      <= 1'b0;
         tx_aborted   <= 1'b0;
         data_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_ok) begin
                  state_q   <= StSetup;
                  remain_q  <= tx_len;
                  ant_flag  <= tx_ant;
                  src_sel   <= 1'b1;
                  tx_busy   <= 1'b1;
                  cnt_q     <= setup_load;
                  aborted_q <= 1'b0;
               end
            end
            StSetup: begin
               if (abort_req) begin
                  state_q   <= StDrain;
                  cnt_q     <= cfg_drain_cycles;
                  aborted_q <= 1'b1;
               end else if (cnt_q == '0) begin
                  state_q <= StStream;
               end else begin
                  cnt_q <= cnt_q - CNT_WIDTH'(1);
               end
            end
            StStream: begin
               if (handshake) begin
                  data_q       <= tx_if.s_data;
                  data_valid_q <= 1'b1;
                  remain_q     <= remain_q - LEN_WIDTH'(1);
               end
               // Completing the last sample wins over a coincident abort.
               if (last_hs) begin
                  state_q <= StDrain;
                  cnt_q   <= cfg_drain_cycles;
               end else if (abort_req) begin
                  state_q   <= StDrain;
                  cnt_q     <= cfg_drain_cycles;
                  aborted_q <= 1'b1;
               end
            end
            StDrain: begin
               if (cnt_q == '0) begin
                  state_q    <= StDone;
                  tx_done    <= 1'b1;
                  tx_aborted <= aborted_q;
               end else begin
                  cnt_q <= cnt_q - CNT_WIDTH'(1);
               end
            end
            StDone: begin
               state_q <= StIdle;
               src_sel <= 1'b0;
               tx_busy <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dac_tx_seq_ctrl.sv
// Bench for dac_tx_seq_ctrl: randomized runs checked against an edge-level model of the sequencer
// (handshake edges, drain length and done timing computed from the stimulus log).
`timescale 1ns/1ps
module tb_dac_tx_seq_ctrl;
   localparam int unsigned IQ_DATA_WIDTH = 16;
   localparam int unsigned LEN_WIDTH     = 16;
   localparam int unsigned CNT_WIDTH     = 8;
   localparam int unsigned MIN_SETUP     = 8;
   localparam int          W             = 2 * IQ_DATA_WIDTH;
   localparam int          MAXE          = 4096;

   logic                 acc_clk = 1'b0;
   logic                 acc_rstn = 1'b0;
   logic                 tx_start = 1'b0;
   logic                 tx_abort = 1'b0;
   logic [LEN_WIDTH-1:0] tx_len = '0;
   logic                 tx_ant = 1'b0;
   logic [CNT_WIDTH-1:0] cfg_setup_cycles = '0;
   logic [CNT_WIDTH-1:0] cfg_drain_cycles = '0;
   logic                 src_sel, ant_flag, tx_busy, tx_done, tx_aborted;
`ifdef DAC_TX_SEQ_UNDERRUN_EN
   logic [CNT_WIDTH-1:0] cfg_underrun_lim = '0;
   logic                 tx_underrun;
`endif

   dac_tx_seq_ctrl_if #(.IQ_DATA_WIDTH(IQ_DATA_WIDTH)) tx_if ();

   dac_tx_seq_ctrl #(
      .IQ_DATA_WIDTH(IQ_DATA_WIDTH),
      .LEN_WIDTH    (LEN_WIDTH),
      .CNT_WIDTH    (CNT_WIDTH),
      .MIN_SETUP    (MIN_SETUP)
   ) dut (
      .acc_clk         (acc_clk),
      .acc_rstn        (acc_rstn),
      .tx_start        (tx_start),
      .tx_abort        (tx_abort),
      .tx_len          (tx_len),
      .tx_ant          (tx_ant),
      .cfg_setup_cycles(cfg_setup_cycles),
      .cfg_drain_cycles(cfg_drain_cycles),
`ifdef DAC_TX_SEQ_UNDERRUN_EN
      .cfg_underrun_lim(cfg_underrun_lim),
      .tx_underrun     (tx_underrun),
`endif
      .tx_if           (tx_if),
      .src_sel         (src_sel),
      .ant_flag        (ant_flag),
      .tx_busy         (tx_busy),
      .tx_done         (tx_done),
      .tx_aborted      (tx_aborted)
   );

   always #5 acc_clk = ~acc_clk;

   // Per-run logs indexed by edge number (edge 1 samples tx_start).
   logic         fulln_at [MAXE];
   logic         valid_at [MAXE];
   logic         rdy_at   [MAXE];
   logic         dv_at    [MAXE];
   logic [W-1:0] d_at     [MAXE];
   logic         done_at  [MAXE];
   logic         abt_at   [MAXE];
   logic         src_at   [MAXE];
   logic         ant_at   [MAXE];
   logic         busy_at  [MAXE];
   logic [W-1:0] src_mem  [MAXE];

   int n = 0;
   int src_idx = 0;
   int n_cmp = 0;
   int n_err = 0;
   int bp_pct = 0;
   int gap_pct = 0;
   int fl_lo = -1;
   int fl_hi = -1;

   // Upstream/FIFO behaviour for the coming edge n+1.
   task automatic drive_next();
      int   e;
      logic f;
      logic v;
      e = n + 1;
      f = ($urandom_range(99) >= bp_pct);
      if (e >= fl_lo && e <= fl_hi) f = 1'b0;
      v = ($urandom_range(99) >= gap_pct);
      tx_if.fulln_from_dac = f;
      tx_if.s_valid        = v;
      tx_if.s_data         = src_mem[src_idx];
      if (e < MAXE) begin
         fulln_at[e] = f;
         valid_at[e] = v;
      end
   endtask

   task automatic tick();
      logic hs;
      @(negedge acc_clk);
      if (n + 1 < MAXE) rdy_at[n+1] = tx_if.s_ready;
      hs = tx_if.s_valid && tx_if.s_ready;
      @(posedge acc_clk);
      #1;
      if (n < MAXE - 2) n++;
      if (hs) src_idx++;
      dv_at[n]   = tx_if.data_valid_to_dac;
      d_at[n]    = tx_if.data_to_dac;
      done_at[n] = tx_done;
      abt_at[n]  = tx_aborted;
      src_at[n]  = src_sel;
      ant_at[n]  = ant_flag;
      busy_at[n] = tx_busy;
      drive_next();
   endtask

   task automatic clear_logs();
      n = 0;
      src_idx = 0;
      for (int i = 0; i < MAXE; i++) begin
         fulln_at[i] = 1'b0; valid_at[i] = 1'b0; rdy_at[i] = 1'b0; dv_at[i] = 1'b0;
         d_at[i] = '0; done_at[i] = 1'b0; abt_at[i] = 1'b0; src_at[i] = 1'b0;
         ant_at[i] = 1'b0; busy_at[i] = 1'b0; src_mem[i] = $urandom;
      end
   endtask

   task automatic run_tx(input string name, input int len, input bit ant, input int setup,
                         input int drain, input int abort_wr, input int abort_edge,
                         input int restart_edge, output int first_wr, output int done_e,
                         output int n_wr);
      int   l, ea, wr, eh, dstart, exp_done, bad, bad_e;
      bit   seen, exp_abt;
      logic exp_r;
      int   exp_q[$];
      int   obs_e[$];
      logic [W-1:0] obs_d[$];
      clear_logs();
      cfg_setup_cycles = CNT_WIDTH'(setup);
      cfg_drain_cycles = CNT_WIDTH'(drain);
      tx_len = LEN_WIDTH'(len);
      tx_ant = ant;
      tx_start = 1'b1;
      drive_next();
      tick();
      // Scramble the request inputs: the run must use the values latched at edge 1.
      tx_start = 1'b0;
      tx_len = LEN_WIDTH'($urandom);
      tx_ant = ~ant;
      ea = -1; wr = 0; seen = 1'b0; done_e = -1;
      if (dv_at[n]) wr++;
      while (!(seen && n >= done_e + 2) && n < 1500) begin
         tx_abort = 1'b0;
         tx_start = 1'b0;
         if (ea < 0 && ((abort_wr >= 0 && wr >= abort_wr) ||
                        (abort_edge > 0 && n + 1 == abort_edge))) begin
            tx_abort = 1'b1;
            ea = n + 1;
         end
         if (n + 1 == restart_edge) begin
            tx_start = 1'b1;
            tx_len = LEN_WIDTH'($urandom_range(1, 500));
         end
         tick();
         if (dv_at[n]) wr++;
         if (!seen && done_at[n]) begin
            seen = 1'b1;
            done_e = n;
         end
      end
      tx_abort = 1'b0;
      tx_start = 1'b0;
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL %s timeout: tx_done not seen within %0d edges", name, n);
      end

      // Model: writes land on the first len stream-window edges offering room and data.
      l = (setup > int'(MIN_SETUP)) ? setup : int'(MIN_SETUP);
      eh = -1;
      for (int e = l + 3; e <= n; e++) begin
         if (ea >= 0 && e > ea) break;
         if (fulln_at[e] && valid_at[e]) begin
            exp_q.push_back(e);
            if (int'(exp_q.size()) == len) begin
               eh = e;
               break;
            end
         end
      end
      if (eh >= 0) begin
         dstart = eh;
         exp_abt = 1'b0;
      end else begin
         dstart = ea;
         exp_abt = 1'b1;
      end
      exp_done = dstart + drain + 1;
      if (exp_done < 0) exp_done = 0;

      for (int e = 1; e <= n; e++) begin
         if (dv_at[e]) begin
            obs_e.push_back(e);
            obs_d.push_back(d_at[e]);
         end
      end
      n_wr = obs_e.size();
      first_wr = (obs_e.size() > 0) ? obs_e[0] : -1;

      n_cmp++;
      if (src_at[1] !== 1'b1 || ant_at[1] !== ant || busy_at[1] !== 1'b1) begin
         n_err++;
         $display("FAIL %s start_outputs: src_sel=%b ant_flag=%b tx_busy=%b, want 1 %b 1",
                  name, src_at[1], ant_at[1], busy_at[1], ant);
      end
      n_cmp++;
      if (obs_e.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL %s write_count: got %0d want %0d", name, obs_e.size(), exp_q.size());
      end
      for (int i = 0; i < obs_e.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_e[i] !== exp_q[i] || obs_d[i] !== src_mem[i]) begin
            n_err++;
            $display("FAIL %s write[%0d]: edge %0d data %h, want edge %0d data %h",
                     name, i, obs_e[i], obs_d[i], exp_q[i], src_mem[i]);
         end
      end
      n_cmp++;
      if (done_e !== exp_done) begin
         n_err++;
         $display("FAIL %s done_edge: got %0d want %0d", name, done_e, exp_done);
      end
      n_cmp++;
      if (abt_at[exp_done] !== exp_abt || {done_at[exp_done+1], abt_at[exp_done+1]} !== 2'b00)
      begin
         n_err++;
         $display("FAIL %s aborted_pulse: tx_aborted=%b then done/abt=%b%b, want %b then 00",
                  name, abt_at[exp_done], done_at[exp_done+1], abt_at[exp_done+1], exp_abt);
      end
      bad = 0; bad_e = -1;
      for (int e = 1; e <= exp_done; e++) begin
         if (src_at[e] !== 1'b1 || ant_at[e] !== ant || busy_at[e] !== 1'b1) begin
            if (bad == 0) bad_e = e;
            bad++;
         end
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL %s hold_src_ant: %0d bad edges, first %0d, want none", name, bad, bad_e);
      end
      n_cmp++;
      if ({src_at[exp_done+1], busy_at[exp_done+1], ant_at[exp_done+1]} !== {2'b00, ant}) begin
         n_err++;
         $display("FAIL %s release: src/busy/ant=%b%b%b want 00%b", name, src_at[exp_done+1],
                  busy_at[exp_done+1], ant_at[exp_done+1], ant);
      end
      bad = 0; bad_e = -1;
      for (int e = 1; e <= n; e++) begin
         exp_r = (e >= l + 3 && e <= dstart) ? fulln_at[e] : 1'b0;
         if (rdy_at[e] !== exp_r) begin
            if (bad == 0) bad_e = e;
            bad++;
         end
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL %s s_ready: %0d bad edges, first %0d, want none", name, bad, bad_e);
      end
   endtask

   task automatic set_policy(input int bp, input int gap, input int lo, input int hi);
      bp_pct = bp; gap_pct = gap; fl_lo = lo; fl_hi = hi;
   endtask

   task automatic test_reset();
      logic [W+6:0] snap;
      tx_if.s_data = '0; tx_if.s_valid = 1'b1; tx_if.fulln_from_dac = 1'b1;
      acc_rstn = 1'b0;
      #12;
      snap = {tx_if.data_to_dac, tx_if.data_valid_to_dac, tx_if.s_ready, src_sel, ant_flag,
              tx_busy, tx_done, tx_aborted};
      n_cmp++;
      if (snap !== '0) begin
         n_err++;
         $display("FAIL reset_state: outputs %h want 0", snap);
      end
      @(negedge acc_clk);
      acc_rstn = 1'b1;
      @(posedge acc_clk);
      #1;
   endtask

   task automatic test_basic();
      int fw, de, nw;
      set_policy(0, 0, -1, -1);
      run_tx("basic", 4, 1'b1, 10, 5, -1, -1, -1, fw, de, nw);
      n_cmp++;
      if (fw != 13 || de != 22 || nw != 4) begin
         n_err++;
         $display("FAIL basic_timing: first_wr=%0d done=%0d writes=%0d, want 13 22 4", fw, de, nw);
      end
   endtask

   task automatic test_min_setup();
      int fw, de, nw;
      set_policy(0, 0, -1, -1);
      run_tx("min_setup", 3, 1'b0, 2, 1, -1, -1, -1, fw, de, nw);
      n_cmp++;
      if (fw != int'(MIN_SETUP) + 3) begin
         n_err++;
         $display("FAIL min_setup_first_write: got edge %0d want %0d", fw, MIN_SETUP + 3);
      end
   endtask

   task automatic test_backpressure();
      int fw, de, nw;
      // FIFO full for stream cycles 3..7 (setup 10 -> stream occupies edges from 13).
      set_policy(0, 0, 15, 19);
      run_tx("backpressure", 8, 1'b1, 10, 3, -1, -1, -1, fw, de, nw);
      n_cmp++;
      if (fw != 13 || nw != 8 || de != 29) begin
         n_err++;
         $display("FAIL bp_timing: first_wr=%0d writes=%0d done=%0d, want 13 8 29", fw, nw, de);
      end
      set_policy(35, 20, -1, -1);
      run_tx("backpressure_rand", 12, 1'b0, 9, 2, -1, -1, -1, fw, de, nw);
   endtask

   task automatic test_abort();
      int fw, de, nw;
      set_policy(0, 0, -1, -1);
      run_tx("abort_stream", 100, 1'b1, 8, 4, 10, -1, -1, fw, de, nw);
      n_cmp++;
      if (nw != 11) begin
         n_err++;
         $display("FAIL abort_write_count: got %0d want 11", nw);
      end
      run_tx("abort_setup", 5, 1'b0, 12, 3, -1, 5, -1, fw, de, nw);
   endtask

   task automatic test_len_zero();
      int bad;
      set_policy(0, 0, -1, -1);
      clear_logs();
      tx_len = '0; tx_ant = 1'b1; tx_start = 1'b1;
      drive_next();
      tick();
      tx_start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      bad = 0;
      for (int e = 1; e <= n; e++) begin
         if (busy_at[e] !== 1'b0 || src_at[e] !== 1'b0 || ant_at[e] !== 1'b0 ||
             rdy_at[e] !== 1'b0 || dv_at[e] !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL len_zero_idle: %0d edges left IDLE outputs, want 0", bad);
      end
   endtask

   task automatic test_start_ignored();
      int fw, de, nw;
      set_policy(10, 10, -1, -1);
      run_tx("start_ignored", 6, 1'b1, 8, 2, -1, -1, 13, fw, de, nw);
      n_cmp++;
      if (nw != 6) begin
         n_err++;
         $display("FAIL start_ignored_count: got %0d writes want 6", nw);
      end
   endtask

   task automatic test_reset_mid();
      int           wr;
      logic [W+6:0] snap;
      set_policy(0, 0, -1, -1);
      clear_logs();
      wr = 0;
      cfg_setup_cycles = CNT_WIDTH'(3); cfg_drain_cycles = CNT_WIDTH'(2);
      tx_len = LEN_WIDTH'(100); tx_ant = 1'b1; tx_start = 1'b1;
      drive_next();
      tick();
      tx_start = 1'b0;
      while (wr < 3 && n < 100) begin
         tick();
         if (dv_at[n]) wr++;
      end
      n_cmp++;
      if (wr < 3) begin
         n_err++;
         $display("FAIL reset_mid_reach_stream: got %0d writes want 3", wr);
      end
      #2 acc_rstn = 1'b0;
      #1;
      snap = {tx_if.data_to_dac, tx_if.data_valid_to_dac, tx_if.s_ready, src_sel, ant_flag,
              tx_busy, tx_done, tx_aborted};
      n_cmp++;
      if (snap !== '0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got %h want 0", snap);
      end
      @(negedge acc_clk);
      acc_rstn = 1'b1;
      @(posedge acc_clk);
      #1;
      n_cmp++;
      if (tx_busy !== 1'b0 || src_sel !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_release: busy=%b src_sel=%b want 0 0", tx_busy, src_sel);
      end
   endtask

   task automatic test_random();
      int fw, de, nw, len, setup, drain, mode, awr, aedge;
      for (int it = 0; it < 6; it++) begin
         len   = $urandom_range(1, 24);
         setup = $urandom_range(0, 14);
         drain = $urandom_range(0, 9);
         mode  = $urandom_range(0, 2);
         awr   = (mode == 1) ? int'($urandom_range(0, len)) : -1;
         aedge = (mode == 2) ? int'($urandom_range(2, 12)) : -1;
         set_policy($urandom_range(0, 40), $urandom_range(0, 30), -1, -1);
         run_tx($sformatf("random%0d", it), len, 1'($urandom_range(0, 1)), setup, drain, awr,
                aedge, -1, fw, de, nw);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_min_setup();
      test_backpressure();
      test_abort();
      test_len_zero();
      test_start_ignored();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, want completion");
      $fatal(1, "timeout");
   end

endmodule
